profile_window_ctrl: RTL

Sequencer for a single profiling counter channel. It drives the counter's clear, start and stop controls around a measurement window bounded by external start and stop triggers, with an optional cycle-limit timeout. After the window closes it captures the counter's final value into a result register. It sits between the debug/CSR command logic and one profiling counter instance.

---
 rtl/profile_window_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/profile_window_ctrl.sv
// Measurement-window sequencer for one profiling counter channel: clears, starts and
// stops the counter around a trigger-bounded window, then captures its final value.
module profile_window_ctrl #(
    parameter int WIDTH = 32,
    parameter int TW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             abort,
    input  logic             trig_start,
    input  logic             trig_stop,
    input  logic [TW-1:0]    limit,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_clear,
    output logic             cnt_start,
    output logic             cnt_stop,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             timed_out
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARMED,
        RUN,
        SETTLE,
        CAPTURE
    } state_t;

    state_t           state, state_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic [TW-1:0]    limit_q, limit_nx;
    logic             clear_nx, start_nx, stop_nx;
    logic             result_valid_nx, timed_out_nx;
    logic [WIDTH-1:0] result_nx;
    logic             timeout_hit;

    assign timeout_hit = (limit_q != '0) && (timer == limit_q - TW'(1));

    // Outputs are computed from the transition and registered, so every pulse is
    // glitch-free and lands in the same cycle as the state it belongs to.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_nx        = state;
        timer_nx        = timer;
        limit_nx        = limit_q;
        clear_nx        = 1'b0;
        start_nx        = 1'b0;
        stop_nx         = 1'b0;
        result_valid_nx = result_valid;
        timed_out_nx    = timed_out;
        result_nx       = result;

        case (state)
            IDLE: begin
                if (arm) begin
                    limit_nx        = limit;
                    result_valid_nx = 1'b0;
                    timed_out_nx    = 1'b0;
                    clear_nx        = 1'b1;
                    state_nx        = CLEAR;
                end
            end
            CLEAR: begin
                state_nx = abort ? IDLE : ARMED;
            end
            ARMED: begin
                if (abort) begin
                    stop_nx  = 1'b1;
                    state_nx = IDLE;
                end else if (trig_start) begin
                    start_nx = 1'b1;
                    timer_nx = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (timer != '1) begin
                    timer_nx = timer + TW'(1);
                end
                if (abort) begin
                    stop_nx  = 1'b1;
                    state_nx = IDLE;
                end else if (trig_stop) begin
                    stop_nx  = 1'b1;
                    state_nx = SETTLE;
                end else if (timeout_hit) begin
                    stop_nx      = 1'b1;
                    timed_out_nx = 1'b1;
                    state_nx     = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    stop_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                result_nx       = cnt_value;
                result_valid_nx = 1'b1;
                state_nx        = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from the values present before the edge.
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            limit_q      <= '0;
            cnt_clear    <= 1'b0;
            cnt_start    <= 1'b0;
            cnt_stop     <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            timed_out    <= 1'b0;
        end else begin
            state        <= state_nx;
            timer        <= timer_nx;
            limit_q      <= limit_nx;
            cnt_clear    <= clear_nx;
            cnt_start    <= start_nx;
            cnt_stop     <= stop_nx;
            busy         <= (state_nx != IDLE);
            result       <= result_nx;
            result_valid <= result_valid_nx;
            timed_out    <= timed_out_nx;
        end
    end

endmodule
